// File: rtl/guitar_pkg.sv
// Shared types and defaults for the strum judging controller.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package guitar_pkg;

  // Default tuning for the judge; the top-level parameters pick these up.
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_STREAK_STEP     = 10;
  localparam int DEF_MAX_MULT        = 4;
  localparam int DEF_BASE_POINTS     = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    JUDGE    = 3'd2,
    REQ      = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  // Multiplier for a given streak: one step per STREAK_STEP hits, clamped at the ceiling.
  function automatic logic [2:0] mult_of(input logic [7:0] s, input int step, input int max_mult);
    int m;
    m = 1 + int'(s) / step;
    if (m > max_mult) m = max_mult;
    return 3'(m);
  endfunction

endpackage

// File: rtl/strum_sync_edge.sv
// Two-flop synchronizer for the raw strum switch plus rising-edge detect.
// Latency: synchronized level 2 cycles after strum_in; rise flagged in that same cycle.
// Backpressure: none, samples every clock.
module strum_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic strum_in,
  output logic strum,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronize the switch and keep one sample of history so an edge needs a seen-low cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= strum_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign strum = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/strum_judge_ctrl.sv
// Debounces a strum, judges frets against notes, tracks streak/multiplier and requests score adds.
// Latency: hit/miss pulse DEBOUNCE_CYCLES+1 cycles after the synchronized strum edge.
// Backpressure: score_req/score_delta hold until score_ack; strums are ignored while waiting.
module strum_judge_ctrl
  import guitar_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STREAK_STEP     = DEF_STREAK_STEP,
  parameter int MAX_MULT        = DEF_MAX_MULT,
  parameter int BASE_POINTS     = DEF_BASE_POINTS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        strum_in,
  input  logic [3:0]  buttons,
  input  logic [3:0]  intersections,
  input  logic        score_ack,
  output logic        score_req,
  output logic [31:0] score_delta,
  output logic [7:0]  streak,
  output logic [2:0]  multiplier,
  output logic        hit_pulse,
  output logic        miss_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             strum;
  logic             rise;
  logic             hit;
  logic [7:0]       streak_inc;
  logic [2:0]       mult_inc;

  strum_sync_edge u_sync (
    .clock    (clock),
    .reset    (reset),
    .strum_in (strum_in),
    .strum    (strum),
    .rise     (rise)
  );

  // Judgment and the post-hit streak/multiplier it would produce.
  always_comb begin
    hit        = (intersections != 4'd0) && (buttons == intersections);
    streak_inc = (streak == 8'hFF) ? 8'hFF : streak + 8'd1;
    mult_inc   = mult_of(streak_inc, STREAK_STEP, MAX_MULT);
  end

  // Next-state and strobe decode; score_req comes straight from the state so reset kills it at once.
  always_comb begin
    state_nxt  = state;
    hit_pulse  = 1'b0;
    miss_pulse = 1'b0;
    score_req  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!strum)                 state_nxt = IDLE;
        else if (cnt == CNT_LAST)   state_nxt = JUDGE;
      end
      JUDGE: begin
        if (hit) begin
          hit_pulse = 1'b1;
          state_nxt = REQ;
        end else begin
          miss_pulse = 1'b1;
          state_nxt  = RELEASE;
        end
      end
      REQ: begin
        score_req = 1'b1;
        if (score_ack) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!strum) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Debounce counter: counts high cycles while debouncing, parked at zero otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          cnt <= '0;
    else if (state == DEBOUNCE && strum) cnt <= cnt + CNT_W'(1);
    else                                cnt <= '0;
  end

  // Streak, multiplier and score amount update only on the judge cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak      <= 8'd0;
      multiplier  <= 3'd1;
      score_delta <= 32'd0;
    end else if (state == JUDGE) begin
      if (hit) begin
        streak      <= streak_inc;
        multiplier  <= mult_inc;
        score_delta <= 32'(BASE_POINTS) * {29'd0, mult_inc};
      end else begin
        streak     <= 8'd0;
        multiplier <= 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_strum_judge_ctrl.sv
// Scoreboard bench for strum_judge_ctrl: judgments queued at stimulus time, checked on pulses.
// Latency: checks hit/miss strobe timing relative to strum_in.
// Backpressure: exercises delayed score_ack and reset while a request is pending.
module tb_strum_judge_ctrl;

  localparam int DEB       = 16;
  localparam int STEP      = 10;
  localparam int MAXM      = 4;
  localparam int BASE      = 1;
  localparam int JUDGE_LAT = 2 + DEB + 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        strum_in;
  logic [3:0]  buttons;
  logic [3:0]  intersections;
  logic        score_ack;
  logic        score_req;
  logic [31:0] score_delta;
  logic [7:0]  streak;
  logic [2:0]  multiplier;
  logic        hit_pulse;
  logic        miss_pulse;

  typedef struct {
    bit          hit;
    logic [7:0]  streak;
    logic [2:0]  mult;
    logic [31:0] delta;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   post = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_streak = 0;

  always #5 clock = ~clock;

  strum_judge_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .STREAK_STEP     (STEP),
    .MAX_MULT        (MAXM),
    .BASE_POINTS     (BASE)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .strum_in      (strum_in),
    .buttons       (buttons),
    .intersections (intersections),
    .score_ack     (score_ack),
    .score_req     (score_req),
    .score_delta   (score_delta),
    .streak        (streak),
    .multiplier    (multiplier),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pops the expected judgment on each strobe and checks the registered results a cycle later.
  always @(negedge clock) begin
    if (reset == 1'b0) begin
      if (post) begin
        post = 1'b0;
        check("streak", streak, cur.streak);
        check("mult", multiplier, cur.mult);
        check("req_after_judge", score_req, cur.hit);
        if (cur.hit) check("delta", score_delta, cur.delta);
      end
      if (hit_pulse || miss_pulse) begin
        check("sb_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          cur  = sb.pop_front();
          post = 1'b1;
          check("hit_kind", hit_pulse, cur.hit);
          check("miss_kind", miss_pulse, !cur.hit);
        end
      end
    end
  end

  // One strum: hold high for 'hold' cycles; ack_wait<0 means reset while the request is pending.
  task automatic do_strum(input int hold, input logic [3:0] b, input logic [3:0] i,
                          input int ack_wait, input bit toggle, input bit judged);
    exp_t e;
    int   lat;
    bit   any;
    bit   stable;
    lat    = -1;
    any    = 1'b0;
    stable = 1'b1;
    e.hit  = (i != 4'd0) && (b == i);
    if (judged) begin
      if (e.hit) begin
        if (m_streak < 255) m_streak++;
        e.mult  = 3'((1 + m_streak / STEP > MAXM) ? MAXM : 1 + m_streak / STEP);
        e.delta = 32'(BASE) * {29'd0, e.mult};
      end else begin
        m_streak = 0;
        e.mult   = 3'd1;
        e.delta  = 32'd0;
      end
      e.streak = 8'(m_streak);
      sb.push_back(e);
    end
    buttons       = b;
    intersections = i;
    strum_in      = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      if ((hit_pulse || miss_pulse) && lat < 0) lat = k;
    end
    @(posedge clock);
    #1 strum_in = 1'b0;
    if (!judged) begin
      repeat (30) begin
        @(negedge clock);
        if (hit_pulse || miss_pulse || score_req) any = 1'b1;
      end
      check("no_judge", any, 0);
    end else begin
      check("latency", lat, JUDGE_LAT);
      if (e.hit && ack_wait > 0) begin
        repeat (ack_wait) begin
          @(negedge clock);
          if (score_req !== 1'b1 || score_delta !== e.delta) stable = 1'b0;
          if (toggle) strum_in = ~strum_in;
        end
        check("req_stable", stable, 1);
        strum_in = 1'b0;
        @(posedge clock);
        #1 score_ack = 1'b1;
        @(posedge clock);
        #1 score_ack = 1'b0;
        @(negedge clock);
        check("req_drop", score_req, 0);
      end else if (e.hit) begin
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_req", score_req, 0);
        check("rst_streak", streak, 0);
        check("rst_mult", multiplier, 1);
        check("rst_delta", score_delta, 0);
        m_streak = 0;
        @(posedge clock);
        #1 reset = 1'b0;
      end
    end
    buttons       = 4'($urandom);
    intersections = 4'($urandom);
    repeat (6) @(posedge clock);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    strum_in      = 1'b0;
    buttons       = 4'd0;
    intersections = 4'd0;
    score_ack     = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst0_req", score_req, 0);
    check("rst0_delta", score_delta, 0);
    check("rst0_streak", streak, 0);
    check("rst0_mult", multiplier, 1);
    check("rst0_hit", hit_pulse, 0);
    check("rst0_miss", miss_pulse, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Stray ack while idle must not matter.
    score_ack = 1'b1;
    repeat (2) @(posedge clock);
    #1 score_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    do_strum(20, 4'b0101, 4'b0101, 3, 1'b0, 1'b1);
    do_strum(5, 4'b0101, 4'b0101, 0, 1'b0, 1'b0);

    for (int n = 2; n <= 39; n++) begin
      logic [3:0] p;
      p = 4'(n % 15 + 1);
      do_strum(20 + n % 3, p, p, 1 + n % 4, 1'b0, 1'b1);
    end

    do_strum(20, 4'b0001, 4'b0011, 3, 1'b0, 1'b1);
    do_strum(20, 4'b0000, 4'b0000, 3, 1'b0, 1'b1);
    do_strum(20, 4'b0111, 4'b0101, 3, 1'b0, 1'b1);
    do_strum(20, 4'b1000, 4'b1000, 2, 1'b0, 1'b1);
    do_strum(20, 4'b0110, 4'b0110, 50, 1'b1, 1'b1);
    do_strum(20, 4'b0011, 4'b0011, -1, 1'b0, 1'b1);
    do_strum(20, 4'b1111, 4'b1111, 2, 1'b0, 1'b1);

    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
